// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
//  Module   : card_dealer
//  Purpose  : Deals 7 distinct cards from a 52-card deck on each start
//             request: player cards 1..2 first, then community cards 1..5.
//             Candidates come from a free-running 16-bit Fibonacci LFSR.
//             Out-of-range or already-used candidates are rejected, and a
//             52-bit used mask prevents duplicates. Card outputs stay stable
//             until the next deal overwrites them slot by slot.
//  Ports    : clk, rst (async, active-high)
//             start        - 1-cycle deal request, ignored unless idle
//             busy         - deal in progress
//             done         - 1-cycle pulse when the 7th card is stored
//             cards_valid  - all card outputs belong to the last full deal
//             *_number     - 0=A,1=2,..,9=10,10=J,11=Q,12=K
//             *_flower     - suit 0..3
//  Revision : 1.0 - initial release
// ============================================================================
module card_dealer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NUM_CARDS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       cards_valid,
    output logic [3:0] player_card1_number,
    output logic [1:0] player_card1_flower,
    output logic [3:0] player_card2_number,
    output logic [1:0] player_card2_flower,
    output logic [3:0] community_card1_number,
    output logic [1:0] community_card1_flower,
    output logic [3:0] community_card2_number,
    output logic [1:0] community_card2_flower,
    output logic [3:0] community_card3_number,
    output logic [1:0] community_card3_flower,
    output logic [3:0] community_card4_number,
    output logic [1:0] community_card4_flower,
    output logic [3:0] community_card5_number,
    output logic [1:0] community_card5_flower
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] c_seed      = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [2:0]  c_last_slot = 3'(NUM_CARDS - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_deal = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_lfsr;
    logic [2:0]  r_count;
    logic [51:0] r_used;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic [3:0]  r_num [NUM_CARDS];
    logic [1:0]  r_flw [NUM_CARDS];

    logic [5:0]  w_cand;
    logic        w_accept;
    logic [3:0]  w_number;
    logic [1:0]  w_flower;
    logic        w_start_deal;
    logic        w_store;
    logic        w_finish;

    // Candidate comes from the current (pre-shift) LFSR value.
    assign w_cand   = r_lfsr[5:0];
    assign w_accept = (w_cand < 6'd52) && !r_used[w_cand];

    // cand -> suit/rank with constant compares instead of a divider.
    always_comb begin
        w_flower = 2'd0;
        w_number = 4'(w_cand);
        if (w_cand >= 6'd39) begin
            w_flower = 2'd3;
            w_number = 4'(w_cand - 6'd39);
        end else if (w_cand >= 6'd26) begin
            w_flower = 2'd2;
            w_number = 4'(w_cand - 6'd26);
        end else if (w_cand >= 6'd13) begin
            w_flower = 2'd1;
            w_number = 4'(w_cand - 6'd13);
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_deal = 1'b0;
        w_store      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt  = c_deal;
                    w_start_deal = 1'b1;
                end
            end
            c_deal: begin
                if (w_accept) begin
                    w_store = 1'b1;
                    if (r_count == c_last_slot) begin
                        w_state_nxt = c_done;
                    end
                end
            end
            c_done: begin
                w_finish    = 1'b1;
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr  <= c_seed;
            r_count <= 3'd0;
            r_used  <= 52'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i < NUM_CARDS; i++) begin
                r_num[i] <= 4'd0;
                r_flw[i] <= 2'd0;
            end
        end else begin
            // Free-running in every state so start timing adds entropy.
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_done <= w_store && (r_count == c_last_slot);

            if (w_start_deal) begin
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
                r_used  <= 52'd0;
                r_count <= 3'd0;
            end

            if (w_store) begin
                r_count <= r_count + 3'd1;
                for (int i = 0; i < 52; i++) begin
                    if (w_cand == 6'(i)) begin
                        r_used[i] <= 1'b1;
                    end
                end
                for (int i = 0; i < NUM_CARDS; i++) begin
                    if (r_count == 3'(i)) begin
                        r_num[i] <= w_number;
                        r_flw[i] <= w_flower;
                    end
                end
            end

            if (w_finish) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign cards_valid = r_valid;

    assign player_card1_number    = r_num[0];
    assign player_card1_flower    = r_flw[0];
    assign player_card2_number    = r_num[1];
    assign player_card2_flower    = r_flw[1];
    assign community_card1_number = r_num[2];
    assign community_card1_flower = r_flw[2];
    assign community_card2_number = r_num[3];
    assign community_card2_flower = r_flw[3];
    assign community_card3_number = r_num[4];
    assign community_card3_flower = r_flw[4];
    assign community_card4_number = r_num[5];
    assign community_card4_flower = r_flw[5];
    assign community_card5_number = r_num[6];
    assign community_card5_flower = r_flw[6];

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_card_dealer
//  Purpose  : Self-checking bench for card_dealer. Two instances: one with
//             the default seed, one with a zero seed (expected to behave as
//             seed 1). Card slots are packed per instance as
//             slot s -> [6s+5:6s+2] number, [6s+1:6s] flower.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_card_dealer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_0 = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    wire        busy_a, done_a, valid_a;
    wire        busy_0, done_0, valid_0;
    wire [41:0] cards_a;
    wire [41:0] cards_0;

    card_dealer #(.SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start_a),
        .busy(busy_a), .done(done_a), .cards_valid(valid_a),
        .player_card1_number(cards_a[5:2]),     .player_card1_flower(cards_a[1:0]),
        .player_card2_number(cards_a[11:8]),    .player_card2_flower(cards_a[7:6]),
        .community_card1_number(cards_a[17:14]), .community_card1_flower(cards_a[13:12]),
        .community_card2_number(cards_a[23:20]), .community_card2_flower(cards_a[19:18]),
        .community_card3_number(cards_a[29:26]), .community_card3_flower(cards_a[25:24]),
        .community_card4_number(cards_a[35:32]), .community_card4_flower(cards_a[31:30]),
        .community_card5_number(cards_a[41:38]), .community_card5_flower(cards_a[37:36])
    );

    card_dealer #(.SEED(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .start(start_0),
        .busy(busy_0), .done(done_0), .cards_valid(valid_0),
        .player_card1_number(cards_0[5:2]),     .player_card1_flower(cards_0[1:0]),
        .player_card2_number(cards_0[11:8]),    .player_card2_flower(cards_0[7:6]),
        .community_card1_number(cards_0[17:14]), .community_card1_flower(cards_0[13:12]),
        .community_card2_number(cards_0[23:20]), .community_card2_flower(cards_0[19:18]),
        .community_card3_number(cards_0[29:26]), .community_card3_flower(cards_0[25:24]),
        .community_card4_number(cards_0[35:32]), .community_card4_flower(cards_0[31:30]),
        .community_card5_number(cards_0[41:38]), .community_card5_flower(cards_0[37:36])
    );

    wire        busy_s  = sel ? busy_0  : busy_a;
    wire        done_s  = sel ? done_0  : done_a;
    wire        valid_s = sel ? valid_0 : valid_a;
    wire [41:0] cards_s = sel ? cards_0 : cards_a;

    int checks   = 0;
    int failures = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR value per instance, free-running like the generator.
    logic [15:0] m_lfsr_a;
    logic [15:0] m_lfsr_0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr_a <= 16'hACE1;
            m_lfsr_0 <= 16'h0001;
        end else begin
            m_lfsr_a <= lfsr_step(m_lfsr_a);
            m_lfsr_0 <= lfsr_step(m_lfsr_0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // From the LFSR value seen at the start edge, draw candidates until
    // seven distinct in-deck cards are found. n = cycles examined,
    // a4 = cycle index at which the fourth card was taken.
    task automatic predict(input logic [15:0] l, output logic [41:0] cards,
                           output int n, output int a4);
        bit          used [52];
        int          cnt;
        int          c;
        logic [15:0] v;
        for (int i = 0; i < 52; i++) used[i] = 1'b0;
        cards = '0;
        cnt = 0;
        n = 0;
        a4 = 0;
        v = l;
        while (cnt < 7 && n < 5000) begin
            v = lfsr_step(v);
            n++;
            c = int'(v[5:0]);
            if (c < 52 && !used[c]) begin
                used[c] = 1'b1;
                cards[cnt*6 +: 6] = {4'(c % 13), 2'(c / 13)};
                cnt++;
                if (cnt == 4) a4 = n;
            end
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_deal(input bit s, input int gap, input bit retrig,
                            input bit abort, output int n_out);
        logic [15:0] l;
        logic [41:0] exp_cards;
        int          n, a4, done_cnt, done_edge;
        bit          busy_ok, valid_ok, aborted, dup, bad_num;
        bit          seen [52];
        int          idx;
        sel = s;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        l = s ? m_lfsr_0 : m_lfsr_a;
        predict(l, exp_cards, n, a4);
        n_out = n;
        if (n >= 5000) begin
            chk("model_bound", 64'(n), 64'd0);
            return;
        end
        if (s) start_0 = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_0 = 1'b0;
        chk("busy_after_start", 64'(busy_s), 64'd1);
        done_cnt = 0;
        done_edge = -1;
        busy_ok = 1'b1;
        valid_ok = 1'b1;
        aborted = 1'b0;
        for (int e = 1; e <= n + 2; e++) begin
            if (retrig && e == 3) begin
                if (s) start_0 = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_0 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done_s) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (e <= n) begin
                if (busy_s !== 1'b1) busy_ok = 1'b0;
                if (valid_s !== 1'b0) valid_ok = 1'b0;
            end
            if (abort && e == a4) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", 64'(busy_s), 64'd0);
                chk("abort_done", 64'(done_s), 64'd0);
                chk("abort_valid", 64'(valid_s), 64'd0);
                chk("abort_cards", 64'(cards_s), 64'd0);
                aborted = 1'b1;
                break;
            end
        end
        start_a = 1'b0;
        start_0 = 1'b0;
        if (aborted) return;
        chk("busy_during_deal", 64'(busy_ok), 64'd1);
        chk("valid_low_during_deal", 64'(valid_ok), 64'd1);
        chk("done_cycle", 64'(done_edge), 64'(n));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("cards", 64'(cards_s), 64'(exp_cards));
        chk("busy_after_done", 64'(busy_s), 64'd0);
        chk("valid_after_done", 64'(valid_s), 64'd1);
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        dup = 1'b0;
        bad_num = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (cards_s[k*6+2 +: 4] > 4'd12) bad_num = 1'b1;
            idx = int'(cards_s[k*6 +: 2]) * 13 + int'(cards_s[k*6+2 +: 4]);
            if (idx < 52) begin
                if (seen[idx]) dup = 1'b1;
                seen[idx] = 1'b1;
            end
        end
        chk("distinct", 64'(dup), 64'd0);
        chk("number_range", 64'(bad_num), 64'd0);
    endtask

    typedef struct {
        bit rst_v;
        bit start_v;
        bit exp_busy;
        bit exp_done;
        bit exp_valid;
        bit exp_zero;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   n;
        vecs[0] = '{1, 0, 0, 0, 0, 1};  // held in reset
        vecs[1] = '{1, 1, 0, 0, 0, 1};  // start ignored in reset
        vecs[2] = '{0, 0, 0, 0, 0, 1};  // idle
        vecs[3] = '{0, 1, 1, 0, 0, 1};  // start edge, nothing dealt yet
        vecs[4] = '{0, 1, 1, 0, 0, 0};  // start held during deal
        vecs[5] = '{0, 0, 1, 0, 0, 0};
        vecs[6] = '{1, 0, 0, 0, 0, 1};  // async reset mid-deal
        vecs[7] = '{1, 0, 0, 0, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst_v;
            start_a = vecs[i].start_v;
            if (vecs[i].rst_v) begin
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("vec%0d_busy", i), 64'(busy_a), 64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 64'(done_a), 64'(vecs[i].exp_done));
            chk($sformatf("vec%0d_valid", i), 64'(valid_a), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_zero)
                chk($sformatf("vec%0d_cards", i), 64'(cards_a), 64'd0);
        end
        start_a = 1'b0;
        @(posedge clk);
        #1;

        // Release reset, start on the first edge.
        rst = 1'b0;
        run_deal(1'b0, 0, 1'b0, 1'b0, n);
        // Back-to-back deal with a second start pulse 3 cycles in.
        run_deal(1'b0, 0, 1'b1, 1'b0, n);
        // Reset after the fourth card, then a fresh deal.
        run_deal(1'b0, 1, 1'b0, 1'b1, n);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_abort_valid", 64'(valid_a), 64'd0);
        chk("post_abort_busy", 64'(busy_a), 64'd0);
        run_deal(1'b0, 2, 1'b0, 1'b0, n);

        // Random start spacing.
        for (int d = 0; d < 2500; d++) begin
            run_deal(1'b0, int'($urandom_range(0, 3)), 1'b0, 1'b0, n);
        end

        // Zero-seed instance behaves as seed 1.
        run_deal(1'b1, 0, 1'b0, 1'b0, n);
        chk("seed0_latency_lt200", 64'(n < 200), 64'd1);
        run_deal(1'b1, 3, 1'b0, 1'b0, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
